// File: rtl/uart_tx.sv
// UART transmitter (8N1, optional parity): serialises one latched byte per accepted request, LSB first.
// Latency: start bit appears one cycle after tx_start is accepted; frame is 10 (11 with parity) bit times.
// Backpressure: tx_busy high while a frame is in flight; tx_start is ignored (not queued) while busy.
//
// Ports:
//   tx_clk   in   1  single clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   tx_start in   1  send request, sampled only in IDLE
//   tx_in    in   8  byte to send, captured on the accepting edge
//   tx_out   out  1  serial line, idle high
//   tx_busy  out  1  frame in progress
//   tx_done  out  1  one-cycle pulse at frame completion
// Optional feature macro: UART_TX_PARITY_EN (adds one parity bit between data and stop).
module uart_tx #(
    parameter int CLKS_PER_BIT = 521,
    parameter int PARITY_ODD   = 0
) (
    input  logic       tx_clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_in,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Elaboration-time sanity checks on the configuration.
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             tx_out_q, tx_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_end;
    logic [2:0]       idx_nxt;

    assign bit_end = (cnt_q == CNT_LAST);
    assign idx_nxt = idx_q + 3'd1;

    // Outputs are computed one cycle ahead so that every output is a flop:
    // the value for the first cycle of a bit is loaded on the edge that ends
    // the previous bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        tx_out_d = tx_out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
                // tx_done cycle is spent here, so a request in that cycle
                // is accepted and frames can run back to back.
                if (tx_start) begin
                    data_d   = tx_in;
                    state_d  = START;
                    tx_out_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = DATA;
                    tx_out_d = data_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        tx_out_d = (^data_q) ^ PARITY_ODD[0];
`else
                        state_d  = STOP;
                        tx_out_d = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_nxt;
                        tx_out_d = data_q[idx_nxt];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = STOP;
                    tx_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    tx_out_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                idx_d    = '0;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: byte scoreboard fed by the stimulus, drained by a line monitor.
// Latency: monitor decodes each frame bit by bit and checks done/busy timing at frame end.
// Backpressure: stimulus only issues new requests when the DUT is idle, except where a test exercises ignored or back-to-back requests.
module tb_uart_tx;

    localparam int N          = 4;
    localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       tx_clk;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] tx_in;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    uart_tx #(
        .CLKS_PER_BIT(N),
        .PARITY_ODD  (PARITY_ODD)
    ) dut (
        .tx_clk  (tx_clk),
        .rst_n   (rst_n),
        .tx_start(tx_start),
        .tx_in   (tx_in),
        .tx_out  (tx_out),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    initial begin
        tx_clk = 1'b0;
        forever #5 tx_clk = ~tx_clk;
    end

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_pushed = 0;
    int         done_cnt = 0;
    int         gap_req  = 0;
    logic [7:0] exp_q[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count every tx_done cycle; a stretched or spurious pulse shows up here.
    initial begin
        forever begin
            @(negedge tx_clk);
            if (rst_n && tx_done) done_cnt++;
        end
    end

    // Line monitor: decodes frames and compares against the scoreboard.
    int hi_run = 0;
    int gap_seen = 0;

    task automatic rx_frame();
        logic [NB-1:0] bits;
        logic          stable;
        logic          ctl_ok;
        logic [7:0]    exp_b;
        bits   = '0;
        stable = 1'b1;
        ctl_ok = 1'b1;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < N; c++) begin
                if (!(b == 0 && c == 0)) begin
                    @(negedge tx_clk);
                    if (!rst_n) begin
                        hi_run = 0;
                        return;
                    end
                end
                if (c == 0) bits[b] = tx_out;
                else if (tx_out !== bits[b]) stable = 1'b0;
                if (tx_busy !== 1'b1 || tx_done !== 1'b0) ctl_ok = 1'b0;
            end
        end
        @(negedge tx_clk);
        if (!rst_n) begin
            hi_run = 0;
            return;
        end
        chk_eq("done_at_frame_end", 32'(tx_done), 32'd1);
        chk_eq("busy_low_at_done", 32'(tx_busy), 32'd0);
        chk_eq("line_high_at_done", 32'(tx_out), 32'd1);
        hi_run = N + 1;
        chk_eq("bit_width_stable", 32'(stable), 32'd1);
        chk_eq("busy_in_frame", 32'(ctl_ok), 32'd1);
        chk_eq("start_bit", 32'(bits[0]), 32'd0);
        chk_eq("stop_bit", 32'(bits[NB-1]), 32'd1);
        if (exp_q.size() == 0) begin
            chk_eq("unexpected_frame", 32'(bits[8:1]), 32'hFFFF_FFFF);
        end else begin
            exp_b = exp_q.pop_front();
            chk_eq("rx_byte", 32'(bits[8:1]), 32'(exp_b));
`ifdef UART_TX_PARITY_EN
            chk_eq("parity_bit", 32'(bits[9]), 32'((^exp_b) ^ PARITY_ODD[0]));
`endif
        end
    endtask

    initial begin
        forever begin
            @(negedge tx_clk);
            if (!rst_n) begin
                hi_run = 0;
            end else if (tx_out === 1'b1) begin
                hi_run++;
            end else begin
                if (gap_req > gap_seen) begin
                    chk_eq("b2b_gap", 32'(hi_run), 32'(N + 1));
                    gap_seen++;
                end
                rx_frame();
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge tx_clk);
        tx_in    = b;
        tx_start = 1'b1;
        exp_q.push_back(b);
        n_pushed++;
        @(negedge tx_clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || tx_busy) && t < 2000) begin
            @(negedge tx_clk);
            t++;
        end
        if (t >= 2000) chk_eq("idle_timeout", 32'(t), 32'd0);
        repeat (3 * N) @(negedge tx_clk);
    endtask

    task automatic wait_sig(input int which, input string tag);
        int t;
        t = 0;
        while (((which == 0) ? tx_busy : tx_done) !== 1'b1 && t < 500) begin
            @(negedge tx_clk);
            t++;
        end
        if (t >= 500) chk_eq(tag, 32'(t), 32'd0);
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        tx_start = 1'b0;
        tx_in    = 8'h00;
        #12;
        // Reset values while held in reset.
        chk_eq("rst_tx_out", 32'(tx_out), 32'd1);
        chk_eq("rst_busy", 32'(tx_busy), 32'd0);
        chk_eq("rst_done", 32'(tx_done), 32'd0);
        @(negedge tx_clk);
        rst_n = 1'b1;

        // Idle with no stimulus for 100 cycles.
        bad = 0;
        repeat (100) begin
            @(negedge tx_clk);
            if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        chk_eq("idle_100", 32'(bad), 32'd0);

        // Single frame.
        send_byte(8'hA5);
        wait_idle();

        // Request during a frame is ignored; tx_in change has no effect.
        @(negedge tx_clk);
        tx_in    = 8'h3C;
        tx_start = 1'b1;
        exp_q.push_back(8'h3C);
        n_pushed++;
        @(negedge tx_clk);
        tx_start = 1'b0;
        repeat (9) @(negedge tx_clk);
        tx_in    = 8'hFF;
        tx_start = 1'b1;
        @(negedge tx_clk);
        tx_start = 1'b0;
        wait_idle();

        // tx_start held high: back-to-back frames, byte re-sampled.
        @(negedge tx_clk);
        tx_in    = 8'h00;
        tx_start = 1'b1;
        exp_q.push_back(8'h00);
        n_pushed++;
        wait_sig(0, "busy_timeout");
        @(negedge tx_clk);
        tx_in = 8'h81;
        exp_q.push_back(8'h81);
        n_pushed++;
        gap_req++;
        wait_sig(1, "done_timeout");
        @(negedge tx_clk);
        tx_start = 1'b0;
        wait_idle();
        chk_eq("gap_checked", 32'(gap_seen), 32'd1);

        // Asynchronous reset mid-frame aborts it without tx_done.
        @(negedge tx_clk);
        tx_in    = 8'h5A;
        tx_start = 1'b1;
        @(negedge tx_clk);
        tx_start = 1'b0;
        repeat (17) @(negedge tx_clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("abort_tx_out", 32'(tx_out), 32'd1);
        chk_eq("abort_busy", 32'(tx_busy), 32'd0);
        chk_eq("abort_done", 32'(tx_done), 32'd0);
        repeat (3) @(negedge tx_clk);
        rst_n = 1'b1;
        send_byte(8'hC3);
        wait_idle();

        // Parity-relevant bytes and a few random ones.
        send_byte(8'h07);
        wait_idle();
        send_byte(8'h03);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            wait_idle();
        end

        chk_eq("done_count", 32'(done_cnt), 32'(n_pushed));
        chk_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
